// File: rtl/pipe_alu_pkg.sv
// Shared opcode encodings and the operation evaluator used by pipe_bitop_alu.
// alu_eval works on zero-extended operands, so a W-bit caller finds its carry at bit W.
package pipe_alu_pkg;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  // Widest operand the evaluator supports; callers zero-extend up to this.
  localparam int unsigned ALU_MAX_W = 64;

  // Returns {carry, y} packed so that for a W-bit caller bit W is the carry
  // and bits above W are zero (inputs must be zero-extended from W bits).
  function automatic logic [ALU_MAX_W:0] alu_eval(
    input logic [1:0]           op,
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b
  );
    logic [ALU_MAX_W:0] res;
    res = '0;
    case (op)
      OP_XOR:  res = {1'b0, a ^ b};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      default: res = {1'b0, a} + {1'b0, b};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipe_alu_stage.sv
// One pipeline slot: a valid bit plus payload, loading whenever it is empty
// or its current contents are taken downstream this cycle.
module pipe_alu_stage #(
  parameter int unsigned DW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_up_valid,
  input  logic [DW-1:0] i_up_data,
  input  logic          i_move,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_load_c
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // An empty slot always loads, which lets bubbles collapse behind a stall.
  assign o_load_c = !r_valid || i_move;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_load_c) begin
      r_valid <= i_up_valid;
      // Payload is retained when the slot empties.
      if (i_up_valid) begin
        r_data <= i_up_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_bitop_alu.sv
// Elastic XOR/AND/OR/ADD datapath: LAT chained stages with valid/ready on both
// sides, bubble collapse and a wrapping delivered-result counter.
module pipe_bitop_alu
  import pipe_alu_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned LAT = 2,
  parameter int unsigned CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y,
  output logic          out_carry,
  output logic          busy,
  output logic [CW-1:0] done_cnt
);

  localparam int unsigned DW = W + 1;

  logic [ALU_MAX_W:0]         w_eval;
  logic [DW-1:0]              w_in_data;
  logic [LAT-1:0]             w_valid;
  logic [LAT-1:0]             w_load;
  logic [LAT-1:0]             w_move;
  logic [LAT-1:0][DW-1:0]     w_data;
  logic [CW-1:0]              r_done_cnt;

  // Result is formed at accept time; payload is {carry, y}.
  assign w_eval    = alu_eval(in_op, ALU_MAX_W'(in_a), ALU_MAX_W'(in_b));
  assign w_in_data = DW'(w_eval);

  for (genvar k = 0; k < int'(LAT); k++) begin : g_stage
    logic          w_up_valid;
    logic [DW-1:0] w_up_data;

    if (k == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_data  = w_in_data;
    end else begin : g_body
      assign w_up_valid = w_valid[k-1];
      assign w_up_data  = w_data[k-1];
    end

    // Ready propagates backwards: a stage moves when the next one loads.
    if (k == int'(LAT) - 1) begin : g_tail
      assign w_move[k] = out_ready;
    end else begin : g_mid
      assign w_move[k] = w_load[k+1];
    end

    pipe_alu_stage #(
      .DW(DW)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_up_valid (w_up_valid),
      .i_up_data  (w_up_data),
      .i_move     (w_move[k]),
      .o_valid    (w_valid[k]),
      .o_data     (w_data[k]),
      .o_load_c   (w_load[k])
    );
  end

  assign in_ready  = w_load[0];
  assign out_valid = w_valid[LAT-1];
  assign out_y     = w_data[LAT-1][W-1:0];
  assign out_carry = w_data[LAT-1][W];
  assign busy      = |w_valid;

  // Count delivered results; wraps naturally at 2^CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else if (w_valid[LAT-1] && out_ready) begin
      r_done_cnt <= r_done_cnt + CW'(1);
    end
  end

  assign done_cnt = r_done_cnt;

endmodule
